pc_next_unit: RTL

//  Next-PC generator with return-address stack (RAS). Feeds d of the 8-bit PC

---
 rtl/pc_next_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//   Next-PC generator for an 8-bit PC register. It picks the sequential,
//   branch, jump, call or return target and keeps call return addresses in a
//   small LIFO return-address stack (RAS).
//
//   pc_next is purely combinational so the PC register can load it on the
//   same clock edge that the RAS commits its push or pop. No latency is added.
//
// Ports
//   clk           rising-edge clock, shared with the PC register
//   reset         synchronous, active-high; clears the RAS and forces pc_next=0
//   pc_q          current PC fed back from the PC register
//   stall         hold the PC; the RAS is left untouched
//   branch_taken  conditional branch resolved as taken
//   branch_off    signed two's-complement branch offset
//   jump          absolute jump to target
//   call          jump to target and push pc_q+1
//   ret           pop the RAS and go to the popped address
//   target        absolute target for jump/call
//   pc_next       next PC, drives the PC register d input
//   ras_count     number of valid RAS entries, 0..DEPTH
//   ras_empty     ras_count == 0
//   ras_full      ras_count == DEPTH
//   ras_ovf       sticky flag: a call arrived while the RAS was full
//   ras_unf       sticky flag: a ret arrived while the RAS was empty
// ---------------------------------------------------------------------------
module pc_next_unit #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_q,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_off,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc_next,
  output logic [SPW:0]  ras_count,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam logic [SPW:0] FULL_CNT = (SPW+1)'(DEPTH);

  logic [AW-1:0]  stack_q [DEPTH];
  logic [SPW:0]   count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           push_en;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  top_entry;
  logic [SPW-1:0] top_idx;
  logic [SPW-1:0] push_idx;
  logic           is_empty;
  logic           is_full;

  // Address math is modulo 2^AW; the offset is two's complement, so a plain
  // AW-bit add gives the sign-extended result for free.
  assign pc_inc    = pc_q + AW'(1);
  assign push_idx  = count_q[SPW-1:0];
  // When the stack is full the low pointer bits wrap to 0, so subtracting one
  // still lands on the last entry.
  assign top_idx   = count_q[SPW-1:0] - SPW'(1);
  assign top_entry = stack_q[top_idx];
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == FULL_CNT);

  // Priority: stall, ret, call, jump, branch, sequential. A simultaneous
  // call and ret resolves as a ret only.
  always_comb begin
    pc_next = pc_inc;
    count_d = count_q;
    push_en = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (reset) begin
      pc_next = '0;
    end else if (stall) begin
      pc_next = pc_q;
    end else if (ret) begin
      if (!is_empty) begin
        pc_next = top_entry;
        count_d = count_q - (SPW+1)'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      pc_next = target;
      if (!is_full) begin
        push_en = 1'b1;
        count_d = count_q + (SPW+1)'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (jump) begin
      pc_next = target;
    end else if (branch_taken) begin
      pc_next = pc_inc + branch_off;
    end
  end

  // RAS storage, pointer and sticky flags; reset overrides any pending push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push_en) begin
        stack_q[push_idx] <= pc_inc;
      end
    end
  end

  assign ras_count = count_q;
  assign ras_empty = is_empty;
  assign ras_full  = is_full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule
